// File: rtl/apb_slave_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_slave_regfile                                      |
// | Description : APB3 responder with a bank of NREG read/write          |
// |               registers, WAIT fixed wait states per transfer,        |
// |               registered prdata/pready/pslverr, flat reg_out.        |
// |               Optional macro APB_SLV_ERR_EN reports decode misses    |
// |               on pslverr; otherwise pslverr is tied low.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apb_slave_regfile #(
   parameter int AW   = 12,
   parameter int DW   = 32,
   parameter int NREG = 8,
   parameter int WAIT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               psel,
   input  logic               penable,
   input  logic               pwrite,
   input  logic [AW-1:0]      paddr,
   input  logic [DW-1:0]      pwdata,
   output logic [DW-1:0]      prdata,
   output logic               pready,
   output logic               pslverr,
   output logic [NREG*DW-1:0] reg_out
);

   localparam int          c_iw       = AW - 2;
   // NREG can equal 2^(AW-2), so the bound needs one extra bit
   localparam logic [c_iw:0] c_nreg     = (c_iw + 1)'(NREG);
   localparam logic [3:0]  c_cnt_init = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic [c_iw-1:0]   r_idx;
   logic              r_hit;
   logic              r_write;
   logic [DW-1:0]     r_regs [NREG];

   logic [c_iw-1:0]   w_idx;
   logic              w_hit;
   logic              w_setup;
   logic              w_enter_done;
   logic [c_iw-1:0]   w_ld_idx;
   logic              w_ld_hit;
   logic              w_ld_write;
   logic [DW-1:0]     w_rd_word;
   logic [DW-1:0]     w_load_val;
   logic              w_err_val;
   logic              w_wr_en;

   // Address decode, and selection of the decode that applies on the edge
   // entering DONE (live bus when coming straight from IDLE, captured otherwise)
   always_comb begin
      w_idx        = paddr[AW-1:2];
      w_hit        = ({1'b0, w_idx} < c_nreg) && (paddr[1:0] == 2'b00);
      w_setup      = psel && !penable;
      w_enter_done = ((r_state == S_IDLE) && w_setup && (WAIT == 0)) ||
                     ((r_state == S_WAIT) && psel && (r_cnt == 4'd0));
      w_ld_idx     = (r_state == S_IDLE) ? w_idx  : r_idx;
      w_ld_hit     = (r_state == S_IDLE) ? w_hit  : r_hit;
      w_ld_write   = (r_state == S_IDLE) ? pwrite : r_write;
      w_rd_word    = '0;
      for (int k = 0; k < NREG; k++) begin
         if (w_ld_idx == c_iw'(k)) begin
            w_rd_word = r_regs[k];
         end
      end
      w_load_val   = (w_ld_hit && !w_ld_write) ? w_rd_word : '0;
`ifdef APB_SLV_ERR_EN
      w_err_val    = !w_ld_hit;
`else
      w_err_val    = 1'b0;
`endif
      w_wr_en      = (r_state == S_DONE) && r_write && r_hit;
   end

   // Transfer sequencing: setup capture, wait-state countdown, abort, completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_hit   <= 1'b0;
         r_write <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_setup) begin
                  r_idx   <= w_idx;
                  r_hit   <= w_hit;
                  r_write <= pwrite;
                  if (WAIT > 0) begin
                     r_state <= S_WAIT;
                     r_cnt   <= c_cnt_init;
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_WAIT: begin
               if (!psel) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Response outputs: pready/pslverr pulse in DONE, prdata holds until next load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prdata  <= '0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
      end else begin
         pready  <= w_enter_done;
         pslverr <= w_enter_done && w_err_val;
         if (w_enter_done) begin
            prdata <= w_load_val;
         end
      end
   end

   // Register bank: a write hit commits on the edge closing DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) begin
            r_regs[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NREG; k++) begin
            if (w_wr_en && (r_idx == c_iw'(k))) begin
               r_regs[k] <= pwdata;
            end
         end
      end
   end

   generate
      for (genvar k = 0; k < NREG; k++) begin : g_out
         assign reg_out[k*DW +: DW] = r_regs[k];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_apb_slave_regfile                                   |
// | Description : Self-checking bench for apb_slave_regfile. Instance 0  |
// |               uses WAIT=2, instance 1 uses WAIT=0. Honours the       |
// |               APB_SLV_ERR_EN macro when forming expected pslverr.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_apb_slave_regfile;

   localparam int NREG = 8;
`ifdef APB_SLV_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         psel    [2];
   logic         penable [2];
   logic         pwrite  [2];
   logic [11:0]  paddr   [2];
   logic [31:0]  pwdata  [2];
   logic [31:0]  prdata  [2];
   logic         pready  [2];
   logic         pslverr [2];
   logic [255:0] reg_out [2];

   int checks   = 0;
   int failures = 0;

   // reference register contents per instance
   logic [31:0] m [2][NREG];

   apb_slave_regfile #(.AW(12), .DW(32), .NREG(NREG), .WAIT(2)) dut (
      .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
      .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
      .reg_out(reg_out[0]));

   apb_slave_regfile #(.AW(12), .DW(32), .NREG(NREG), .WAIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
      .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
      .reg_out(reg_out[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wait_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] exp_regout(input int d);
      logic [255:0] v;
      for (int k = 0; k < NREG; k++) v[k*32 +: 32] = m[d][k];
      return v;
   endfunction

   // Reference behaviour: a word-aligned address below NREG*4 is a hit
   task automatic model_apply(input int d, input bit wr, input logic [11:0] a,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic err);
      int  idx;
      bit  hit;
      idx = int'(a) / 4;
      hit = (a % 4 == 0) && (idx < NREG);
      rd  = 32'h0;
      if (hit && wr)  m[d][idx] = wd;
      if (hit && !wr) rd = m[d][idx];
      err = ERR_EN && !hit;
   endtask

   // One APB transfer; lat = negedges from setup until pready (0 = timeout)
   task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic err, output int lat);
      @(negedge clk);
      chk($sformatf("reg_out_before_xfer_d%0d", d), reg_out[d], exp_regout(d));
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
      lat = 0; rd = '0; err = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         penable[d] = 1'b1;
         if (pready[d]) begin
            lat = n; rd = prdata[d]; err = pslverr[d];
            break;
         end
      end
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   // Transfer checked against the reference model
   task automatic run(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd);
      logic [31:0] rd, erd;
      logic        err, eerr;
      int          lat;
      xfer(d, wr, a, wd, rd, err, lat);
      model_apply(d, wr, a, wd, erd, eerr);
      chk($sformatf("latency_d%0d_a%0h", d, a), 256'(lat), 256'(wait_of(d) + 1));
      chk($sformatf("prdata_d%0d_a%0h", d, a), 256'(rd), 256'(erd));
      chk($sformatf("pslverr_d%0d_a%0h", d, a), 256'(err), 256'(eerr));
   endtask

   typedef struct {
      int          d;
      bit          wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      bit          exp_miss;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [31:0] rd, drd;
      logic        err, derr;
      int          lat, seen;
      logic [11:0] a;

      tbl[0] = '{1, 1'b1, 12'h000, 32'h0000_0001, 32'h0,         1'b0};
      tbl[1] = '{1, 1'b0, 12'h000, 32'h0,         32'h0000_0001, 1'b0};
      tbl[2] = '{0, 1'b1, 12'h004, 32'hDEAD_BEEF, 32'h0,         1'b0};
      tbl[3] = '{0, 1'b0, 12'h004, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tbl[4] = '{0, 1'b1, 12'h020, 32'h0000_0055, 32'h0,         1'b1};
      tbl[5] = '{0, 1'b0, 12'h002, 32'h0,         32'h0,         1'b1};

      for (int d = 0; d < 2; d++) begin
         psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0; pwdata[d] = '0;
         for (int k = 0; k < NREG; k++) m[d][k] = '0;
      end

      // reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_pready_d%0d", d), 256'(pready[d]), 256'(0));
         chk($sformatf("reset_prdata_d%0d", d), 256'(prdata[d]), 256'(0));
         chk($sformatf("reset_pslverr_d%0d", d), 256'(pslverr[d]), 256'(0));
         chk($sformatf("reset_reg_out_d%0d", d), reg_out[d], 256'(0));
      end
      rst_n = 1'b1;

      // directed table
      for (int i = 0; i < 6; i++) begin
         xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, err, lat);
         model_apply(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, drd, derr);
         chk($sformatf("tbl%0d_latency", i), 256'(lat), 256'(wait_of(tbl[i].d) + 1));
         chk($sformatf("tbl%0d_prdata", i), 256'(rd), 256'(tbl[i].exp_rd));
         chk($sformatf("tbl%0d_pslverr", i), 256'(err), 256'(ERR_EN && tbl[i].exp_miss));
         if (i == 3)
            chk("reg1_after_deadbeef", 256'(reg_out[0][63:32]), 256'(32'hDEAD_BEEF));
      end
      @(negedge clk);
      chk("reg_out_after_misses", reg_out[0], exp_regout(0));

      // abort: psel dropped in the second wait cycle of a write to reg 2
      @(negedge clk);
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h008; pwdata[0] = 32'hA5;
      @(negedge clk);
      penable[0] = 1'b1;
      seen = 0;
      @(negedge clk);
      psel[0] = 1'b0; penable[0] = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (pready[0]) seen++;
      end
      chk("abort_pready_seen", 256'(seen), 256'(0));
      chk("abort_reg2", 256'(reg_out[0][95:64]), 256'(0));
      run(0, 1'b0, 12'h008, 32'h0);
      run(0, 1'b1, 12'h008, 32'h1234_5678);
      run(0, 1'b0, 12'h008, 32'h0);

      // randomized traffic, ~3/4 word aligned, addresses spanning hits and misses
      for (int i = 0; i < 80; i++) begin
         a = 12'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         run(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
      end

      // reset in the middle of a write transfer
      run(0, 1'b1, 12'h01C, 32'hCAFE_F00D);
      run(0, 1'b0, 12'h01C, 32'h0);
      @(negedge clk);
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h00C; pwdata[0] = 32'h1234;
      @(negedge clk);
      penable[0] = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_pready", 256'(pready[0]), 256'(0));
      chk("midrst_prdata", 256'(prdata[0]), 256'(0));
      chk("midrst_pslverr", 256'(pslverr[0]), 256'(0));
      chk("midrst_reg_out0", reg_out[0], 256'(0));
      chk("midrst_reg_out1", reg_out[1], 256'(0));
      @(negedge clk);
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < NREG; k++) m[d][k] = '0;
      run(0, 1'b0, 12'h00C, 32'h0);
      run(0, 1'b1, 12'h000, 32'h0BAD_C0DE);
      run(1, 1'b1, 12'h01C, 32'h7777_0001);
      run(1, 1'b0, 12'h01C, 32'h0);
      @(negedge clk);
      chk("final_reg_out0", reg_out[0], exp_regout(0));
      chk("final_reg_out1", reg_out[1], exp_regout(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
